// File: rtl/jt900h_opfetch.sv
`default_nettype none
// ============================================================================
// Module   : jt900h_opfetch
// Brief    : 8-byte op-code prefetch queue fed by a 16-bit little-endian bus.
// Revision : 1.0
// ============================================================================
module jt900h_opfetch #(
    parameter logic [23:0] PC_RST = 24'h000000
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [1:0]  fetched,
    input  logic        jmp_en,
    input  logic [23:0] jmp_addr,
    output logic [31:0] op,
    output logic        op_ok,
    output logic [23:0] pc,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_ok
);

    logic [7:0]  queue_q [8];
    logic [7:0]  queue_d [8];
    logic [3:0]  count_q, count_d;
    logic [23:0] pc_q, pc_d;
    logic [23:0] bus_addr_q, bus_addr_d;
    logic        bus_rd_q, bus_rd_d;

    logic [3:0]  pop_n;
    logic [3:0]  count_mid;
    logic [3:0]  src_idx;
    logic [2:0]  wr_idx;
    logic        beat;

    assign op_ok    = (count_q >= 4'd4);
    assign pc       = pc_q;
    assign bus_addr = bus_addr_q;
    assign bus_rd   = bus_rd_q;

    // Entries past the occupancy are forced to zero on the window.
    always_comb begin
        op = '0;
        for (int i = 0; i < 4; i++) begin
            if (count_q > 4'(i)) op[8*i +: 8] = queue_q[i];
        end
    end

    always_comb begin
        queue_d    = queue_q;
        count_d    = count_q;
        pc_d       = pc_q;
        bus_addr_d = bus_addr_q;
        bus_rd_d   = bus_rd_q;
        pop_n      = op_ok ? {2'b00, fetched} : 4'd0;
        count_mid  = count_q - pop_n;
        beat       = bus_rd_q & bus_ok;
        src_idx    = '0;
        wr_idx     = count_mid[2:0];

        if (cen) begin
            if (jmp_en) begin
                for (int i = 0; i < 8; i++) queue_d[i] = '0;
                count_d    = '0;
                pc_d       = jmp_addr;
                bus_addr_d = jmp_addr;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    src_idx    = 4'(i) + pop_n;
                    queue_d[i] = (src_idx < 4'd8) ? queue_q[src_idx[2:0]] : 8'd0;
                end
                count_d = count_mid;
                pc_d    = pc_q + {22'd0, pop_n[1:0]};
                // Odd addresses only deliver the high byte of the word.
                if (beat) begin
                    if (bus_addr_q[0]) begin
                        queue_d[wr_idx] = bus_din[15:8];
                        count_d         = count_mid + 4'd1;
                        bus_addr_d      = bus_addr_q + 24'd1;
                    end else begin
                        queue_d[wr_idx]        = bus_din[7:0];
                        queue_d[wr_idx + 3'd1] = bus_din[15:8];
                        count_d                = count_mid + 4'd2;
                        bus_addr_d             = bus_addr_q + 24'd2;
                    end
                end
            end
            bus_rd_d = (count_d <= 4'd6) && !jmp_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) queue_q[i] <= '0;
            count_q    <= '0;
            pc_q       <= PC_RST;
            bus_addr_q <= PC_RST;
            bus_rd_q   <= 1'b0;
        end else begin
            queue_q    <= queue_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            bus_addr_q <= bus_addr_d;
            bus_rd_q   <= bus_rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt900h_opfetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt900h_opfetch
// Brief    : Directed table plus randomized run against an address-level model.
// Revision : 1.0
// ============================================================================
module tb_jt900h_opfetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [1:0]  fetched = 2'd0;
    logic        jmp_en = 1'b0;
    logic [23:0] jmp_addr = 24'd0;
    logic        bus_ok = 1'b0;
    logic [15:0] bus_din;
    logic [31:0] op;
    logic        op_ok;
    logic [23:0] pc;
    logic [23:0] bus_addr;
    logic        bus_rd;

    int errors = 0;
    int checks = 0;

    jt900h_opfetch #(.PC_RST(24'h000000)) dut (
        .rst(rst), .clk(clk), .cen(cen), .fetched(fetched),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .op(op), .op_ok(op_ok),
        .pc(pc), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_din(bus_din), .bus_ok(bus_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [23:0] a);
        return 8'(a[7:0] + 3 * a[15:8] + 5 * a[23:16]);
    endfunction

    assign bus_din = {mem({bus_addr[23:1], 1'b1}), mem({bus_addr[23:1], 1'b0})};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: the queue is always mem[m_pc .. m_pc+m_cnt-1].
    logic [23:0] m_pc, m_fa;
    int          m_cnt;
    logic        m_rd;

    task automatic model_reset();
        m_pc = 24'd0; m_fa = 24'd0; m_cnt = 0; m_rd = 1'b0;
    endtask

    task automatic model_step();
        int n;
        if (!cen) return;
        if (jmp_en) begin
            m_cnt = 0; m_pc = jmp_addr; m_fa = jmp_addr; m_rd = 1'b0;
            return;
        end
        if (m_cnt >= 4) begin
            m_pc  = m_pc + 24'(fetched);
            m_cnt = m_cnt - int'(fetched);
        end
        if (m_rd && bus_ok) begin
            n     = m_fa[0] ? 1 : 2;
            m_cnt = m_cnt + n;
            m_fa  = m_fa + 24'(n);
        end
        m_rd = (m_cnt <= 6);
    endtask

    function automatic logic [31:0] model_op();
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (i < m_cnt) r[8*i +: 8] = mem(m_pc + 24'(i));
        return r;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, " pc"},       {8'd0, pc},       {8'd0, m_pc});
        check({tag, " op_ok"},    {31'd0, op_ok},   {31'd0, (m_cnt >= 4)});
        check({tag, " op"},       op,               model_op());
        check({tag, " bus_addr"}, {8'd0, bus_addr}, {8'd0, m_fa});
        check({tag, " bus_rd"},   {31'd0, bus_rd},  {31'd0, m_rd});
    endtask

    typedef struct {
        logic        cen;
        logic [1:0]  fetched;
        logic        jmp;
        logic [23:0] ja;
        logic        bok;
        logic [23:0] pc;
        logic        ok;
        logic [23:0] ba;
        logic        rd;
        logic [31:0] op;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic [1:0] f, input logic j, input logic [23:0] ja,
                       input logic b, input logic [23:0] epc, input logic eok,
                       input logic [23:0] eba, input logic erd, input logic [31:0] eop);
        vec_t v;
        v.cen = c; v.fetched = f; v.jmp = j; v.ja = ja; v.bok = b;
        v.pc = epc; v.ok = eok; v.ba = eba; v.rd = erd; v.op = eop;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset boot, then fetched = 1, 3, 2, then saturation with fetched = 0
        add(1, 0, 0, 24'h0, 1, 24'h000000, 0, 24'h000000, 1, 32'h00000000);
        add(1, 0, 0, 24'h0, 1, 24'h000000, 0, 24'h000002, 1, 32'h00000100);
        add(1, 0, 0, 24'h0, 1, 24'h000000, 1, 24'h000004, 1, 32'h03020100);
        add(1, 1, 0, 24'h0, 1, 24'h000001, 1, 24'h000006, 1, 32'h04030201);
        add(1, 3, 0, 24'h0, 1, 24'h000004, 1, 24'h000008, 1, 32'h07060504);
        add(1, 2, 0, 24'h0, 1, 24'h000006, 1, 24'h00000A, 1, 32'h09080706);
        add(1, 0, 0, 24'h0, 1, 24'h000006, 1, 24'h00000C, 1, 32'h09080706);
        add(1, 0, 0, 24'h0, 1, 24'h000006, 1, 24'h00000E, 0, 32'h09080706);
        add(1, 0, 0, 24'h0, 1, 24'h000006, 1, 24'h00000E, 0, 32'h09080706);
        add(0, 3, 0, 24'h0, 1, 24'h000006, 1, 24'h00000E, 0, 32'h09080706);
        // Jump with a coinciding beat and pop, to an odd address
        add(1, 2, 1, 24'h000101, 1, 24'h000101, 0, 24'h000101, 0, 32'h00000000);
        add(1, 0, 0, 24'h0, 1, 24'h000101, 0, 24'h000101, 1, 32'h00000000);
        add(1, 0, 0, 24'h0, 1, 24'h000101, 0, 24'h000102, 1, 32'h00000004);
        add(1, 0, 0, 24'h0, 1, 24'h000101, 0, 24'h000104, 1, 32'h00060504);
        add(1, 0, 0, 24'h0, 1, 24'h000101, 1, 24'h000106, 1, 32'h07060504);
        // Wrap at the top of the address space, with a frozen cycle mid-request
        add(1, 0, 1, 24'hFFFFFE, 1, 24'hFFFFFE, 0, 24'hFFFFFE, 0, 32'h00000000);
        add(1, 0, 0, 24'h0, 1, 24'hFFFFFE, 0, 24'hFFFFFE, 1, 32'h00000000);
        add(0, 0, 0, 24'h0, 1, 24'hFFFFFE, 0, 24'hFFFFFE, 1, 32'h00000000);
        add(1, 0, 0, 24'h0, 1, 24'hFFFFFE, 0, 24'h000000, 1, 32'h0000F7F6);
        add(1, 0, 0, 24'h0, 1, 24'hFFFFFE, 1, 24'h000002, 1, 32'h0100F7F6);
        add(1, 2, 0, 24'h0, 1, 24'h000000, 1, 24'h000004, 1, 32'h03020100);
        add(1, 2, 0, 24'h0, 1, 24'h000002, 1, 24'h000006, 1, 32'h05040302);

        #2;
        check("reset op",       op,               32'd0);
        check("reset op_ok",    {31'd0, op_ok},   32'd0);
        check("reset pc",       {8'd0, pc},       32'd0);
        check("reset bus_addr", {8'd0, bus_addr}, 32'd0);
        check("reset bus_rd",   {31'd0, bus_rd},  32'd0);
        #5 rst = 1'b0;

        foreach (tbl[k]) begin
            cen = tbl[k].cen; fetched = tbl[k].fetched; jmp_en = tbl[k].jmp;
            jmp_addr = tbl[k].ja; bus_ok = tbl[k].bok;
            @(posedge clk);
            #1;
            check($sformatf("row%0d pc", k),       {8'd0, pc},       {8'd0, tbl[k].pc});
            check($sformatf("row%0d op_ok", k),    {31'd0, op_ok},   {31'd0, tbl[k].ok});
            check($sformatf("row%0d op", k),       op,               tbl[k].op);
            check($sformatf("row%0d bus_addr", k), {8'd0, bus_addr}, {8'd0, tbl[k].ba});
            check($sformatf("row%0d bus_rd", k),   {31'd0, bus_rd},  {31'd0, tbl[k].rd});
        end

        // Asynchronous reset while a request may be pending
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_model("async rst");
        #2 rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            cen     = ($urandom_range(0, 9) != 0);
            bus_ok  = ($urandom_range(0, 9) < 6);
            fetched = 2'($urandom_range(0, 3));
            jmp_en  = ($urandom_range(0, 39) == 0);
            jmp_addr = ($urandom_range(0, 1) == 0) ? 24'(24'hFFFFF8 + $urandom_range(0, 7))
                                                    : 24'($urandom);
            @(posedge clk);
            model_step();
            #1;
            compare_model("rnd");
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                compare_model("rnd rst");
                #2 rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt900h_opfetch.md
JT900H_OPFETCH -- requirements
Module: jt900h_opfetch

Interface
REQ-001 SHALL have parameter PC_RST, default 24'h000000, meaning the byte address fetched after reset.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port cen, input, 1, clock enable; state changes only when cen=1.
REQ-005 SHALL have port fetched, input, 2, bytes consumed by the controller this cycle (0..3).
REQ-006 SHALL have port jmp_en, input, 1, flush request with a new fetch address.
REQ-007 SHALL have port jmp_addr, input, 24, target byte address for jmp_en.
REQ-008 SHALL have port op, output, 32, op-code window; op[7:0] is the oldest queued byte and op[31:24] the 4th oldest.
REQ-009 SHALL have port op_ok, output, 1, window valid.
REQ-010 SHALL have port pc, output, 24, address of the byte on op[7:0].
REQ-011 SHALL have port bus_addr, output, 24, memory read address, registered.
REQ-012 SHALL have port bus_rd, output, 1, memory read request, registered.
REQ-013 SHALL have port bus_din, input, 16, read data, little-endian; [7:0] is the even byte.
REQ-014 SHALL have port bus_ok, input, 1, read data valid / request accepted.

Function
REQ-015 SHALL hold an 8-byte FIFO queue with a 4-bit occupancy count (0..8).
REQ-016 SHALL drive op from queue entries 0..3; entries beyond count SHALL read as 0.
REQ-017 SHALL assert op_ok combinationally when count>=4.
REQ-018 SHALL honour fetched only when op_ok=1 and cen=1: pop fetched bytes and add fetched to pc; fetched is ignored when op_ok=0.
REQ-019 SHALL accept a bus beat on a cen edge where bus_rd=1 and bus_ok=1.
REQ-020 On an accepted beat with bus_addr[0]=0, SHALL push 2 bytes (din[7:0] first) and advance bus_addr by 2.
REQ-021 On an accepted beat with bus_addr[0]=1, SHALL push only din[15:8] and advance bus_addr by 1.
REQ-022 SHALL handle a pop and a push on the same edge: pushed bytes go after the remaining bytes, and count_next = count - popped + pushed.
REQ-023 SHALL keep at most one request outstanding, with bus_addr stable while bus_rd=1 and bus_ok=0.
REQ-024 SHALL set bus_rd at each cen edge to (count_next<=6) and not jmp_en, where count_next is the post-edge occupancy.
REQ-025 SHALL make 24-bit pc and bus_addr wrap from FFFFFF to 000000.
REQ-026 On jmp_en=1, SHALL set count=0, pc=jmp_addr, bus_addr=jmp_addr and bus_rd=0, with priority over pop and push.
REQ-027 SHALL discard a bus_ok beat that coincides with jmp_en.
REQ-028 With zero-wait memory (bus_ok=1), SHALL raise bus_rd 1 edge after a jump and op_ok 3 edges after a jump to an even address.
REQ-029 With zero-wait memory, a jump to an odd address SHALL reach count>=4 after 4 edges (1+2+2 bytes).
REQ-030 SHALL freeze all state when cen=0, including a beat presented on that cycle.

Reset
REQ-031 On rst=1, SHALL clear count and all queue bytes to 0, so that op=0 and op_ok=0.
REQ-032 On rst=1, SHALL set pc=PC_RST, bus_addr=PC_RST and bus_rd=0.
REQ-033 Asserting rst mid-request SHALL abandon the request; a late bus_ok after reset release SHALL be accepted only if bus_rd=1.
REQ-034 After rst release, SHALL issue the first request on the first cen edge.

Verification
REQ-035 Reset then zero-wait memory with bytes 00 01 02 03 04 at 0x000000 -> bus_rd=1 after edge 1; op=32'h03020100 and op_ok=1 after edge 3; pc=0.
REQ-036 Apply fetched=1, then 3, then 2 with continuous memory -> pc=1, 4, 6; op[7:0]=01, 04, 06.
REQ-037 Jump to 0x000101 (odd) -> first beat pushes only the byte at 0x101; bus_addr sequence 0x101, 0x102, 0x104; op[7:0]=mem[0x101].
REQ-038 Hold fetched=0 with memory always ready -> count saturates at 8 (or 7 after an odd start); bus_rd=0 while count>6; no byte lost or duplicated.
REQ-039 Assert jmp_en together with bus_ok=1 and fetched=2 -> count=0, pc=jmp_addr, beat discarded; next bus_addr=jmp_addr.
REQ-040 Jump to 0xFFFFFE, consume 4 bytes -> bus_addr wraps to 0x000000; pc=0x000002; op bytes taken from FFFFFE, FFFFFF, 000000, 000001.
